// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline.
// Resolves load-use, taken-branch and data-memory wait hazards.
module pipe_hazard_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rrwrite,
  input  logic             mem_memread,
  input  logic             mem_memwrite,
  input  logic             mem_pcsrc,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_write,
  output logic             exmem_flush,
  output logic             memwb_bubble,
  output logic             dmem_req,
  output logic             mem_err,
  output logic             in_wait,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  localparam logic [15:0] LAST = 16'(TIMEOUT - 1);

  state_t      state, state_n;
  logic [15:0] wait_cnt, wait_cnt_n;
  logic        memop, lu, release_c, freeze;
  logic        brn, luse, err_set;

  assign memop = mem_memread | mem_memwrite;
  assign lu = ex_memread && (ex_rrwrite != 5'd0)
           && (ex_rrwrite == id_rs || ex_rrwrite == id_rt);

  assign release_c = dmem_ready || (wait_cnt == LAST);
  assign err_set   = (state == MEM_WAIT) && !dmem_ready
                  && (wait_cnt == LAST);

  // Mutually exclusive event terms encode the priority order.
  always_comb begin
    freeze = 1'b0;
    if (state == RUN)
      freeze = memop && !dmem_ready;
    else
      freeze = !release_c;
  end

  assign brn  = !freeze && mem_pcsrc;
  assign luse = !freeze && !mem_pcsrc && lu;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      wait_cnt    <= '0;
      mem_err     <= 1'b0;
      stall_count <= '0;
    end else begin
      state    <= state_n;
      wait_cnt <= wait_cnt_n;
      if (err_set)
        mem_err <= 1'b1;
      if (!pc_write && !(&stall_count))
        stall_count <= stall_count + 1'b1;
    end
  end

  always_comb begin
    state_n    = state;
    wait_cnt_n = wait_cnt;
    unique case (state)
      RUN: begin
        if (freeze) begin
          state_n    = MEM_WAIT;
          wait_cnt_n = 16'd1;
        end
      end
      MEM_WAIT: begin
        if (release_c) begin
          state_n    = RUN;
          wait_cnt_n = '0;
        end else begin
          wait_cnt_n = wait_cnt + 16'd1;
        end
      end
      default: begin
        state_n    = RUN;
        wait_cnt_n = '0;
      end
    endcase
  end

  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    exmem_write  = 1'b1;
    exmem_flush  = 1'b0;
    memwb_bubble = 1'b0;
    dmem_req     = memop || (state == MEM_WAIT);
    in_wait      = (state == MEM_WAIT);
    if (rst) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      exmem_write  = 1'b0;
      dmem_req     = 1'b0;
      in_wait      = 1'b0;
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
      exmem_flush  = 1'b1;
      memwb_bubble = 1'b1;
    end else begin
      unique case (1'b1)
        freeze: begin
          pc_write     = 1'b0;
          ifid_write   = 1'b0;
          exmem_write  = 1'b0;
          memwb_bubble = 1'b1;
        end
        brn: begin
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          exmem_flush = 1'b1;
        end
        luse: begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_flush = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl.
// Stimulus pushes expected outputs; a monitor checks them.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  id_rs = '0, id_rt = '0, ex_rrwrite = '0;
  logic        ex_memread = 1'b0;
  logic        mem_memread = 1'b0, mem_memwrite = 1'b0;
  logic        mem_pcsrc = 1'b0, dmem_ready = 1'b0;
  logic        pc_write, ifid_write, ifid_flush, idex_flush;
  logic        exmem_write, exmem_flush, memwb_bubble;
  logic        dmem_req, mem_err, in_wait;
  logic [15:0] stall_count;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.TIMEOUT(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt),
    .ex_memread(ex_memread), .ex_rrwrite(ex_rrwrite),
    .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
    .mem_pcsrc(mem_pcsrc), .dmem_ready(dmem_ready),
    .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_write(exmem_write), .exmem_flush(exmem_flush),
    .memwb_bubble(memwb_bubble), .dmem_req(dmem_req),
    .mem_err(mem_err), .in_wait(in_wait),
    .stall_count(stall_count)
  );

  // {pc_w, ifid_w, ifid_f, idex_f, exmem_w, exmem_f, bubble, req, wait}
  localparam logic [8:0] RST = 9'b001101100;
  localparam logic [8:0] DEF = 9'b110010000;
  localparam logic [8:0] LU  = 9'b000110000;
  localparam logic [8:0] BR  = 9'b111111000;
  localparam logic [8:0] FRZ = 9'b000000110;
  localparam logic [8:0] FRW = 9'b000000111;
  localparam logic [8:0] REL = 9'b110010011;
  localparam logic [8:0] ZW  = 9'b110010010;
  localparam logic [8:0] ZWL = 9'b000110010;
  localparam logic [8:0] RBR = 9'b111111011;

  typedef struct {
    int         id;
    logic [8:0] v;
    int         cnt;
    logic       err;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0, n_fail = 0, step_id = 0;
  bit   done = 1'b0;

  task automatic step(input logic r, input logic [4:0] rs,
                      input logic [4:0] rt, input logic er,
                      input logic [4:0] ed, input logic mr,
                      input logic mw, input logic pcs,
                      input logic rdy, input logic [8:0] ev,
                      input int ec, input logic ee);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; id_rs = rs; id_rt = rt;
    ex_memread = er; ex_rrwrite = ed;
    mem_memread = mr; mem_memwrite = mw;
    mem_pcsrc = pcs; dmem_ready = rdy;
    step_id++;
    e.id = step_id; e.v = ev; e.cnt = ec; e.err = ee;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic [8:0] a;
    if (q.size() > 0) begin
      e = q.pop_front();
      a = {pc_write, ifid_write, ifid_flush, idex_flush,
           exmem_write, exmem_flush, memwb_bubble,
           dmem_req, in_wait};
      n_chk++;
      if (a !== e.v) begin
        n_fail++;
        $display("FAIL ctrl step %0d: got %b want %b", e.id, a, e.v);
      end
      n_chk++;
      if (stall_count !== 16'(e.cnt)) begin
        n_fail++;
        $display("FAIL stall_count step %0d: got %0d want %0d",
                 e.id, stall_count, e.cnt);
      end
      n_chk++;
      if (mem_err !== e.err) begin
        n_fail++;
        $display("FAIL mem_err step %0d: got %b want %b",
                 e.id, mem_err, e.err);
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    //   rst rs    rt    er ed    mr mw pc rd exp  cnt err
    step(1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, RST, 0, 0);
    step(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, DEF, 0, 0);
    step(0, 5'd5, 5'd1, 1, 5'd5, 0, 0, 0, 0, LU,  0, 0);
    step(0, 5'd5, 5'd1, 0, 5'd0, 0, 0, 0, 0, DEF, 1, 0);
    step(0, 5'd0, 5'd0, 1, 5'd0, 0, 0, 0, 0, DEF, 1, 0);
    step(0, 5'd2, 5'd7, 1, 5'd7, 0, 0, 0, 0, LU,  1, 0);
    step(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, DEF, 2, 0);
    step(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0, BR,  2, 0);
    step(0, 5'd5, 5'd0, 1, 5'd5, 0, 0, 1, 0, BR,  2, 0);
    step(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, DEF, 2, 0);
    step(0, 5'd0, 5'd0, 0, 5'd0, 1, 0, 0, 0, FRZ, 2, 0);
    step(0, 5'd0, 5'd0, 0, 5'd0, 1, 0, 0, 0, FRW, 3, 0);
    step(0, 5'd0, 5'd0, 0, 5'd0, 1, 0, 0, 0, FRW, 4, 0);
    step(0, 5'd0, 5'd0, 0, 5'd0, 1, 0, 0, 1, REL, 5, 0);
    step(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, DEF, 5, 0);
    step(0, 5'd0, 5'd0, 0, 5'd0, 1, 0, 0, 1, ZW,  5, 0);
    step(0, 5'd5, 5'd0, 1, 5'd5, 0, 1, 0, 1, ZWL, 5, 0);
    step(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, DEF, 6, 0);
    step(0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, 0, FRZ, 6, 0);
    step(0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 1, 0, FRW, 7, 0);
    step(0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 1, 1, RBR, 8, 0);
    step(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, DEF, 8, 0);
    step(0, 5'd0, 5'd0, 0, 5'd0, 1, 0, 0, 0, FRZ, 8, 0);
    step(0, 5'd0, 5'd0, 0, 5'd0, 1, 0, 0, 0, FRW, 9, 0);
    step(0, 5'd0, 5'd0, 0, 5'd0, 1, 0, 0, 0, FRW, 10, 0);
    step(0, 5'd0, 5'd0, 0, 5'd0, 1, 0, 0, 0, REL, 11, 0);
    step(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, DEF, 11, 1);
    step(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, DEF, 11, 1);
    step(0, 5'd0, 5'd0, 0, 5'd0, 1, 0, 0, 0, FRZ, 11, 1);
    step(0, 5'd0, 5'd0, 0, 5'd0, 1, 0, 0, 0, FRW, 12, 1);
    step(1, 5'd0, 5'd0, 0, 5'd0, 1, 0, 0, 0, RST, 13, 1);
    step(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, DEF, 0, 0);
    step(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, DEF, 0, 0);
    done = 1'b1;
  end

  initial begin
    int budget;
    budget = 0;
    while (!(done && q.size() == 0) && budget < 200) begin
      @(posedge clk);
      budget++;
    end
    if (budget >= 200) begin
      n_chk++;
      n_fail++;
      $display("FAIL timeout: %0d entries pending, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline. Drives write-enables and flushes of PC, IF/ID, ID/EX, EX/MEM and MEM/WB from three sources:
- load-use hazards detected between ID and EX;
- taken branches resolved in MEM;
- a variable-latency data-memory handshake that freezes the pipe until the access completes.
Sits beside the pipeline registers; owns no datapath.

Parameters:
TIMEOUT, 64, max cycles in MEM_WAIT before abort (range 2..65535)
CNT_W, 16, width of stall_count

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
id_rs  in  5  rs field of instruction in ID
id_rt  in  5  rt field of instruction in ID
ex_memread  in  1  instruction in EX is a load
ex_rrwrite  in  5  destination register of instruction in EX
mem_memread  in  1  load in MEM
mem_memwrite  in  1  store in MEM
mem_pcsrc  in  1  branch in MEM is taken
dmem_ready  in  1  data memory completes the current access this cycle
pc_write  out  1  PC update enable
ifid_write  out  1  IF/ID load enable
ifid_flush  out  1  IF/ID clear to NOP
idex_flush  out  1  ID/EX clear control bits (bubble)
exmem_write  out  1  EX/MEM load enable
exmem_flush  out  1  EX/MEM clear control bits
memwb_bubble  out  1  MEM/WB loads a bubble (regwrite=0)
dmem_req  out  1  data-memory request
mem_err  out  1  sticky timeout flag
in_wait  out  1  FSM is in MEM_WAIT
stall_count  out  CNT_W  saturating count of cycles with pc_write=0 (excluding reset)

Behaviour:
- States: RUN, MEM_WAIT. State, wait_cnt, mem_err and stall_count are registered. All other outputs are combinational from state and inputs; zero latency.
- Reset (rst=1 at edge): state=RUN, wait_cnt=0, mem_err=0, stall_count=0.
- While rst is high:
  - pc_write=0, ifid_write=0, exmem_write=0, dmem_req=0, in_wait=0.
  - ifid_flush=1, idex_flush=1, exmem_flush=1, memwb_bubble=1.
- Definitions:
  - memop = mem_memread | mem_memwrite.
  - lu = ex_memread & (ex_rrwrite!=0) & (ex_rrwrite==id_rs | ex_rrwrite==id_rt).
- Default (no event): pc_write=1, ifid_write=1, exmem_write=1; all flushes, memwb_bubble and dmem_req are 0.
- Priority in RUN: memory stall > branch flush > load-use.
- RUN, memop=1:
  - dmem_req=1.
  - If dmem_ready=1: single-cycle access, no stall; then evaluate the lower-priority sources normally.
  - If dmem_ready=0: freeze with pc_write=0, ifid_write=0, exmem_write=0, idex_flush=0 (ID/EX holds because its own enable is tied to exmem_write), memwb_bubble=1. Next state MEM_WAIT, wait_cnt<=1.
- RUN, mem_pcsrc=1 (no stall): ifid_flush=1, idex_flush=1, exmem_flush=1, pc_write=1 (branched PC loads). Any coincident load-use is ignored.
- RUN, lu=1 (no stall, no branch): pc_write=0, ifid_write=0, idex_flush=1, exmem_write=1. One cycle only; next cycle lu re-evaluates to 0 because the load has moved to MEM.
- MEM_WAIT:
  - dmem_req=1, in_wait=1; freeze outputs as above.
  - If dmem_ready=1: release this cycle with default enables and memwb_bubble=0. Branch and load-use are evaluated in the same cycle with RUN rules. Next state RUN, wait_cnt<=0.
  - Else if wait_cnt==TIMEOUT-1: mem_err<=1 (sticky), release exactly as on ready, next state RUN.
  - Else wait_cnt<=wait_cnt+1.
- mem_pcsrc together with memop is not produced by the decoder. If it does occur, the stall wins; the branch is honoured on the release cycle because EX/MEM is held.
- stall_count increments on each cycle with rst=0 and pc_write=0, saturating at all-ones.
- A rst asserted mid-MEM_WAIT aborts the access: dmem_req drops in that same cycle, and the FSM is in RUN after the edge.

Test Plan:
- Load-use: lw writes r5 in EX, ID reads rs=5 → exactly one cycle with pc_write=0, ifid_write=0, idex_flush=1; stall_count=1. Same with ex_rrwrite=0 → no stall.
- Branch: mem_pcsrc=1 in RUN → ifid_flush, idex_flush, exmem_flush all 1 for one cycle, pc_write=1; simultaneous lu=1 gives no extra stall.
- Memory wait: load in MEM, dmem_ready low 3 cycles then high → in_wait high for 3 cycles, dmem_req high for 4 cycles, memwb_bubble=1 for 3 cycles, stall_count=3, release on the 4th cycle.
- Timeout: TIMEOUT=4, dmem_ready held low → release on the 4th cycle of the stall, mem_err=1 and stays 1 until rst.
- Reset mid-wait: rst in the 2nd MEM_WAIT cycle → dmem_req=0 the same cycle, state RUN, stall_count=0, mem_err=0.
- Zero-wait access: memop with dmem_ready=1 in the same cycle → no stall, in_wait never asserts.
